sd_sector_packer: RTL

//  Upstream feeder for the SD-card writer. Collects the recorder byte stream into
//  two ping-pong sector banks. Issues one write command per closed bank:
//    - wr_start pulse with a byte count
//    - the writer then reads the bank through a registered read port.
//  A flush request closes a partially filled sector at clip end.

---
 rtl/sd_sector_packer.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_packer.sv
// sd_sector_packer
//  Packs the recorder byte stream into two ping-pong sector banks and hands each
//  closed bank to the SD-card writer. The writer gets a wr_start pulse with a
//  byte count, then reads the bank through a registered read port. A flush
//  request closes a partially filled sector at the end of a clip.
//
//  Optional feature macro: SD_PACK_PAD_EN
//    defined   - a flush-closed partial bank is padded with PAD_BYTE up to
//                SECTOR_BYTES (one byte per cycle) and issued as a full sector.
//    undefined - a flush-closed partial bank is issued as-is with its fill count.
module sd_sector_packer #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned ADDR_W       = 9,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              wr_start,
    output logic [15:0]       wr_bytes,
    input  logic              wr_busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [15:0]       sectors_issued
);

    // Both banks share one array; the bank index is the top address bit.
    localparam int unsigned MEM_DEPTH  = 2 * (2 ** ADDR_W);
    localparam logic [15:0] FULL_COUNT = 16'(SECTOR_BYTES);
    localparam logic [15:0] LAST_INDEX = 16'(SECTOR_BYTES - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        ISSUE_IDLE    = 2'd0,
        ISSUE_START   = 2'd1,
        ISSUE_WAIT    = 2'd2,
        ISSUE_RELEASE = 2'd3
    } issue_state_t;

    // Bank bookkeeping
    bank_state_t  bank_state [2];
    logic [15:0]  bank_count [2];
    logic [7:0]   bank_mem   [MEM_DEPTH];

    // Fill side
    logic         fill_bank;
    logic [15:0]  fill_cnt;
    logic         flush_pend;
    logic         pad_active;

    // Issue side
    issue_state_t issue_state;
    logic         drain_bank;

    // Derived controls
    logic         fill_open;
    logic         other_bank;
    logic         other_free;
    logic         releasing;
    logic         wr_en;
    logic [7:0]   wr_byte;
    logic         last_byte;
    logic         flush_close;
    logic         close_now;
    logic [15:0]  close_count;
    logic         banks_empty;
    logic         full0;
    logic         full1;
    logic         pick_bank;

    // The fill bank accepts bytes while it is not closed; a pending flush
    // freezes input until everything buffered has been written out.
    assign fill_open  = (bank_state[fill_bank] != BANK_FULL);
    assign in_ready   = fill_open && !flush_pend;
    assign other_bank = ~fill_bank;
    assign releasing  = (issue_state == ISSUE_RELEASE);
    // A bank being released this cycle counts as free so the fill side can
    // claim it on the same edge.
    assign other_free = (bank_state[other_bank] == BANK_EMPTY) ||
                        (releasing && (drain_bank == other_bank));
    assign wr_en      = (in_valid && in_ready) || pad_active;
    assign wr_byte    = pad_active ? PAD_BYTE : in_data;
    assign last_byte  = wr_en && (fill_cnt == LAST_INDEX);
    // Only a bank holding data is closed by a flush; the pad engine blocks a
    // second trigger while it is running.
    assign flush_close = flush_pend && !pad_active && (fill_cnt != 16'd0);
    assign banks_empty = (bank_state[0] == BANK_EMPTY) && (bank_state[1] == BANK_EMPTY);
    assign full0       = (bank_state[0] == BANK_FULL);
    assign full1       = (bank_state[1] == BANK_FULL);

`ifdef SD_PACK_PAD_EN
    // Pad engine: after a flush closes a partial bank, keep writing PAD_BYTE
    // until the last byte of the sector has been written.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_active <= 1'b0;
        end else if (flush_close) begin
            pad_active <= 1'b1;
        end else if (last_byte) begin
            pad_active <= 1'b0;
        end else begin
            pad_active <= pad_active;
        end
    end

    // A padded bank is only ever closed by its final byte.
    assign close_now = last_byte;
`else
    assign pad_active = 1'b0;
    // A partial bank closes immediately with whatever it holds.
    assign close_now  = last_byte || flush_close;
`endif

    // Closing count and drain-bank selection; when both banks are full the
    // one the fill pointer is not on is the older of the two.
    always_comb begin
        close_count = fill_cnt;
        pick_bank   = 1'b0;
        if (last_byte) begin
            close_count = FULL_COUNT;
        end else begin
            close_count = fill_cnt;
        end
        if (full0 && full1) begin
            pick_bank = ~fill_bank;
        end else if (full1) begin
            pick_bank = 1'b1;
        end else begin
            pick_bank = 1'b0;
        end
    end

    // Bank state tracking: release empties the drain bank, the fill side marks
    // its bank filling on the first byte and full when it closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            bank_count[0] <= 16'd0;
            bank_count[1] <= 16'd0;
        end else begin
            if (releasing) begin
                bank_state[drain_bank] <= BANK_EMPTY;
            end else begin
                bank_state[drain_bank] <= bank_state[drain_bank];
            end
            if (close_now) begin
                bank_state[fill_bank] <= BANK_FULL;
                bank_count[fill_bank] <= close_count;
            end else if (wr_en && (bank_state[fill_bank] == BANK_EMPTY)) begin
                bank_state[fill_bank] <= BANK_FILLING;
            end else begin
                bank_count[fill_bank] <= bank_count[fill_bank];
            end
        end
    end

    // Fill pointer and byte counter: advance on every written byte, restart at
    // close, and move to the other bank as soon as it is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank <= 1'b0;
            fill_cnt  <= 16'd0;
        end else begin
            if (close_now) begin
                fill_cnt <= 16'd0;
            end else if (wr_en) begin
                fill_cnt <= fill_cnt + 16'd1;
            end else begin
                fill_cnt <= fill_cnt;
            end
            if ((close_now || !fill_open) && other_free) begin
                fill_bank <= other_bank;
            end else begin
                fill_bank <= fill_bank;
            end
        end
    end

    // Flush handshake: latch the request, then signal completion once nothing
    // is left in either bank. Requests during a pending flush are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (!flush_pend) begin
                flush_pend <= flush;
            end else if (banks_empty && (fill_cnt == 16'd0)) begin
                flush_pend <= 1'b0;
                flush_done <= 1'b1;
            end else begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Sector storage write port (stream bytes and pad bytes share it).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[{fill_bank, fill_cnt[ADDR_W-1:0]}] <= wr_byte;
        end
    end

    // Writer read port: one-cycle registered read from the drain bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= bank_mem[{drain_bank, rd_addr}];
        end
    end

    // Issue FSM: lock the oldest full bank, pulse wr_start, wait for the
    // writer to go idle, then release the bank and count it.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_state    <= ISSUE_IDLE;
            drain_bank     <= 1'b0;
            wr_start       <= 1'b0;
            wr_bytes       <= 16'd0;
            sectors_issued <= 16'd0;
        end else begin
            case (issue_state)
                ISSUE_IDLE: begin
                    if (full0 || full1) begin
                        drain_bank  <= pick_bank;
                        wr_bytes    <= bank_count[pick_bank];
                        wr_start    <= 1'b1;
                        issue_state <= ISSUE_START;
                    end else begin
                        wr_start    <= 1'b0;
                        issue_state <= ISSUE_IDLE;
                    end
                end
                ISSUE_START: begin
                    wr_start    <= 1'b0;
                    issue_state <= ISSUE_WAIT;
                end
                ISSUE_WAIT: begin
                    wr_start <= 1'b0;
                    if (!wr_busy) begin
                        issue_state <= ISSUE_RELEASE;
                    end else begin
                        issue_state <= ISSUE_WAIT;
                    end
                end
                ISSUE_RELEASE: begin
                    wr_start       <= 1'b0;
                    sectors_issued <= sectors_issued + 16'd1;
                    issue_state    <= ISSUE_IDLE;
                end
                default: begin
                    wr_start    <= 1'b0;
                    issue_state <= ISSUE_IDLE;
                end
            endcase
        end
    end

endmodule
